gen_phasor: RTL and testbench

Inverse of the angle calculator: converts a 16-bit binary angle and a 7-bit magnitude into an 8-bit signed real/imaginary pair, `real = mag·cos(angle)` and `imag = mag·sin(angle)`. It uses an iterative rotation-mode CORDIC at one micro-rotation per clock. It sits on the same `val`-qualified sample stream, so phasor test vectors and reference carriers can be regenerated from angles.

---
 rtl/gen_phasor_if.sv | 21 ++
 rtl/gen_phasor.sv | 154 +++++++++++++++
 tb/tb_gen_phasor.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/gen_phasor_if.sv
// gen_phasor_if: sample-stream bundle between an angle source and gen_phasor.
// Request side: val_i, angle_i, mag_i. Result side: real_o, imag_o, val_o, busy_o.
interface gen_phasor_if;
    logic               val_i;
    logic        [15:0] angle_i;
    logic        [6:0]  mag_i;
    logic signed [7:0]  real_o;
    logic signed [7:0]  imag_o;
    logic               val_o;
    logic               busy_o;

    modport master (
        output val_i, angle_i, mag_i,
        input  real_o, imag_o, val_o, busy_o
    );

    modport slave (
        input  val_i, angle_i, mag_i,
        output real_o, imag_o, val_o, busy_o
    );
endinterface

// File: rtl/gen_phasor.sv
// gen_phasor: iterative rotation-mode CORDIC, binary angle + magnitude -> cos/sin.
// Ports: clk, rst_n (async, active-low), bus (gen_phasor_if.slave).
module gen_phasor #(
    parameter int ITER = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    gen_phasor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, ROT, OUT} state_t;

    state_t             state;
    state_t             state_nxt;
    logic        [15:0] angle_q;
    logic        [6:0]  mag_q;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
    logic        [3:0]  cnt;
    logic signed [7:0]  real_q;
    logic signed [7:0]  imag_q;

    logic        [14:0] mag_scaled;
    logic               flip;
    logic signed [15:0] x0;
    logic signed [15:0] z0;
    logic signed [15:0] xs;
    logic signed [15:0] ys;
    logic signed [15:0] atan;
    logic signed [15:0] x_nxt;
    logic signed [15:0] y_nxt;
    logic signed [15:0] z_nxt;
    logic               last;

    function automatic logic signed [15:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    atan_lut = 16'sd8192;
            4'd1:    atan_lut = 16'sd4836;
            4'd2:    atan_lut = 16'sd2555;
            4'd3:    atan_lut = 16'sd1297;
            4'd4:    atan_lut = 16'sd651;
            4'd5:    atan_lut = 16'sd326;
            4'd6:    atan_lut = 16'sd163;
            4'd7:    atan_lut = 16'sd81;
            4'd8:    atan_lut = 16'sd41;
            4'd9:    atan_lut = 16'sd20;
            4'd10:   atan_lut = 16'sd10;
            4'd11:   atan_lut = 16'sd5;
            4'd12:   atan_lut = 16'sd3;
            4'd13:   atan_lut = 16'sd1;
            default: atan_lut = 16'sd0;
        endcase
    endfunction

    // Round half up to 1/256 units, then clamp symmetric so -128 never appears.
    function automatic logic signed [7:0] rnd_sat(input logic signed [15:0] v);
        logic signed [16:0] t;
        t = ($signed({v[15], v}) + 17'sd128) >>> 8;
        if (t > 17'sd127)
            rnd_sat = 8'sd127;
        else if (t < -17'sd127)
            rnd_sat = -8'sd127;
        else
            rnd_sat = 8'(t);
    endfunction

    // 155/256 pre-scales by ~1/K so the CORDIC gain lands back on mag.
    assign mag_scaled = {8'd0, mag_q} * 15'd155;
    // Second/third quadrant: rotate the start vector by pi and the angle by -pi.
    assign flip = (angle_q[15:14] == 2'b01) || (angle_q[15:14] == 2'b10);
    assign x0   = flip ? -$signed({1'b0, mag_scaled}) : $signed({1'b0, mag_scaled});
    assign z0   = flip ? angle_q - 16'h8000 : angle_q;

    assign xs   = x >>> cnt;
    assign ys   = y >>> cnt;
    assign atan = atan_lut(cnt);
    assign last = (cnt == 4'(ITER - 1));

    always_comb begin
        x_nxt = x - ys;
        y_nxt = y + xs;
        z_nxt = z - atan;
        if (z[15]) begin
            x_nxt = x + ys;
            y_nxt = y - xs;
            z_nxt = z + atan;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.val_i) state_nxt = LOAD;
            LOAD: state_nxt = ROT;
            ROT:  if (last) state_nxt = OUT;
            OUT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            angle_q <= '0;
            mag_q   <= '0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            cnt     <= '0;
            real_q  <= '0;
            imag_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.val_i) begin
                        angle_q <= bus.angle_i;
                        mag_q   <= bus.mag_i;
                    end
                end
                LOAD: begin
                    x   <= x0;
                    y   <= '0;
                    z   <= z0;
                    cnt <= '0;
                end
                ROT: begin
                    x   <= x_nxt;
                    y   <= y_nxt;
                    z   <= z_nxt;
                    cnt <= cnt + 4'd1;
                    // Results land on the edge that enters OUT, alongside val_o.
                    if (last) begin
                        real_q <= rnd_sat(x_nxt);
                        imag_q <= rnd_sat(y_nxt);
                    end
                end
                OUT: cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

    assign bus.real_o = real_q;
    assign bus.imag_o = imag_q;
    assign bus.val_o  = (state == OUT);
    assign bus.busy_o = (state != IDLE);
endmodule

// File: tb/tb_gen_phasor.sv
// tb_gen_phasor: randomized scoreboard bench for gen_phasor against a
// real-valued cos/sin model.
module tb_gen_phasor;
    localparam int ITER = 12;
    localparam int LAT  = ITER + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gen_phasor_if bus ();

    gen_phasor #(.ITER(ITER)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int    er;
        int    ei;
        int    tol;
        string name;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   vcount = 0;
    time  t_acc  = 0;

    task automatic check(input string name, input int act, input int exp, input int tol);
        int d;
        d = act - exp;
        if (d < 0) d = -d;
        checks++;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    function automatic int model(input logic [15:0] a, input int m, input bit is_cos);
        real th;
        th = 2.0 * 3.14159265358979 * real'(a) / 65536.0;
        if (is_cos)
            return int'(real'(m) * $cos(th));
        return int'(real'(m) * $sin(th));
    endfunction

    // Monitor: every val_o pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && bus.val_o) begin
            exp_t e;
            vcount++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_val_o: got pulse (%0d,%0d), want none",
                         bus.real_o, bus.imag_o);
            end else begin
                e = sbq.pop_front();
                check({e.name, "_re"}, int'(bus.real_o), e.er, e.tol);
                check({e.name, "_im"}, int'(bus.imag_o), e.ei, e.tol);
                check({e.name, "_no128"},
                      ((bus.real_o == -8'sd128) || (bus.imag_o == -8'sd128)) ? 1 : 0, 0, 0);
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [6:0] m,
                        input int tol, input string nm);
        int   g;
        exp_t e;
        g = 0;
        @(negedge clk);
        while (bus.busy_o && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_wait_idle: got busy_o=1, want 0 within 100 cycles", nm);
        end
        bus.angle_i = a;
        bus.mag_i   = m;
        bus.val_i   = 1'b1;
        @(posedge clk);
        t_acc  = $time;
        e.er   = model(a, int'(m), 1'b1);
        e.ei   = model(a, int'(m), 1'b0);
        e.tol  = tol;
        e.name = nm;
        sbq.push_back(e);
        #1;
        bus.val_i = 1'b0;
    endtask

    task automatic drain(input string nm);
        int g;
        g = 0;
        while (sbq.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check({nm, "_drain"}, sbq.size(), 0, 0);
        sbq.delete();
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, want finish before 5 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0;
        int  v0;

        bus.val_i   = 1'b0;
        bus.angle_i = '0;
        bus.mag_i   = '0;
        #1;
        check("rst_real", int'(bus.real_o), 0, 0);
        check("rst_imag", int'(bus.imag_o), 0, 0);
        check("rst_val",  int'(bus.val_o), 0, 0);
        check("rst_busy", int'(bus.busy_o), 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Latency and busy window for a single request.
        send(16'h0000, 7'd127, 1, "axis_0000");
        for (int n = 1; n <= LAT + 2; n++) begin
            @(negedge clk);
            check($sformatf("lat_busy_c%0d", n), int'(bus.busy_o), (n <= LAT) ? 1 : 0, 0);
            check($sformatf("lat_val_c%0d", n), int'(bus.val_o), (n == LAT) ? 1 : 0, 0);
        end
        drain("lat");

        send(16'h4000, 7'd127, 1, "axis_4000");
        send(16'h8000, 7'd127, 1, "axis_8000");
        send(16'hC000, 7'd127, 1, "axis_c000");
        send(16'h2000, 7'd100, 2, "diag_2000");
        send(16'hA000, 7'd100, 2, "diag_a000");
        send(16'hE000, 7'd100, 2, "diag_e000");
        send(16'h1234, 7'd0,   0, "mag0_1234");
        drain("points");

        // A request pulsed while busy must be dropped.
        v0 = vcount;
        send(16'h0000, 7'd127, 1, "rej_first");
        repeat (5) @(negedge clk);
        bus.angle_i = 16'h4000;
        bus.mag_i   = 7'd127;
        bus.val_i   = 1'b1;
        @(negedge clk);
        bus.val_i = 1'b0;
        drain("rej");
        repeat (3) @(negedge clk);
        check("rej_one_pulse", vcount - v0, 1, 0);
        send(16'h4000, 7'd127, 1, "rej_next");
        drain("rej_next");

        // Reset in the middle of a rotation.
        send(16'h2000, 7'd100, 2, "abandon");
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_real", int'(bus.real_o), 0, 0);
        check("mid_rst_imag", int'(bus.imag_o), 0, 0);
        check("mid_rst_val",  int'(bus.val_o), 0, 0);
        check("mid_rst_busy", int'(bus.busy_o), 0, 0);
        sbq.delete();
        v0 = vcount;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_rst_no_val", vcount - v0, 0, 0);
        send(16'h0000, 7'd90, 2, "after_rst");
        drain("after_rst");

        // Back-to-back random traffic, also checking request spacing.
        send(16'($urandom), 7'($urandom_range(0, 127)), 2, "rnd");
        for (int k = 0; k < 1500; k++) begin
            t0 = t_acc;
            send(16'($urandom), 7'($urandom_range(0, 127)), 2, "rnd");
            check("rnd_gap", int'((t_acc - t0) / 10), ITER + 3, 0);
        end
        drain("rnd");

        // Strided sweep at full magnitude.
        for (int k = 0; k < 1000; k++)
            send(16'(k * 67 + 5), 7'd127, 2, "sweep");
        drain("sweep");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
